multicycle_ctrl: RTL

- Multi-cycle sequencer for the register/ALU/memory datapath driven by the opcode decoder.
- Accepts one instruction per handshake and steps it through DECODE/EXEC/MEM/WB.
- Drives alu_op, reg_write, mem_read, mem_write and reg_dst per state, and waits on a memory acknowledge with a timeout.
- Counts retired instructions; flags illegal opcodes and memory timeouts.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/ctrl_opdecode.sv | 26 ++
 rtl/multicycle_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode constants and enums for the multi-cycle sequencer and its opcode decoder.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_LW  = 6'h04;
  localparam logic [5:0] OP_SW  = 6'h05;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_ILL
  } cls_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction handshake, memory acknowledge and datapath control bundle of the sequencer.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [5:0]       opcode;
  logic             instr_ready;
  logic             mem_ack;
  logic [2:0]       alu_op;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_read;
  logic             mem_write;
  logic             done;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  // master issues instructions and acknowledges memory; slave is the sequencer
  modport master (
    output instr_valid, opcode, mem_ack,
    input  instr_ready, alu_op, reg_write, reg_dst, mem_read, mem_write,
           done, illegal, mem_err, retired
  );

  modport slave (
    input  instr_valid, opcode, mem_ack,
    output instr_ready, alu_op, reg_write, reg_dst, mem_read, mem_write,
           done, illegal, mem_err, retired
  );
endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decode: ALU function, instruction class and destination select.
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output alu_op_e    alu_op,
  output cls_e       cls,
  output logic       reg_dst
);

  always_comb begin
    alu_op  = ALU_ADD;
    cls     = CLS_ILL;
    reg_dst = 1'b0;
    case (opcode)
      OP_ADD: begin alu_op = ALU_ADD; cls = CLS_R; reg_dst = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB; cls = CLS_R; reg_dst = 1'b1; end
      OP_AND: begin alu_op = ALU_AND; cls = CLS_R; reg_dst = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;  cls = CLS_R; reg_dst = 1'b1; end
      OP_LW:  cls = CLS_LW;
      OP_SW:  cls = CLS_SW;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB sequencer with memory-ack timeout and retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_reg;
  logic [5:0]        ir_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic [CNT_W-1:0]  retired_reg;

  alu_op_e dec_alu;
  cls_e    dec_cls;
  logic    dec_rd;

  ctrl_opdecode u_opdecode (
    .opcode  (ir_reg),
    .alu_op  (dec_alu),
    .cls     (dec_cls),
    .reg_dst (dec_rd)
  );

  logic in_mem;
  logic ack_hit;
  logic timeout_hit;
  logic done_w;

  // ack beats timeout when both land on the last allowed MEM cycle
  assign in_mem      = (state_reg == ST_MEM);
  assign ack_hit     = in_mem && bus.mem_ack;
  assign timeout_hit = in_mem && !bus.mem_ack && (wait_reg == WAIT_LAST);
  assign done_w      = (state_reg == ST_WB) || (ack_hit && dec_cls == CLS_SW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ir_reg      <= '0;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      if (done_w) retired_reg <= retired_reg + CNT_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            ir_reg    <= bus.opcode;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: state_reg <= (dec_cls == CLS_ILL) ? ST_IDLE : ST_EXEC;
        ST_EXEC: begin
          wait_reg  <= '0;
          state_reg <= (dec_cls == CLS_R) ? ST_WB : ST_MEM;
        end
        ST_MEM: begin
          if (ack_hit)          state_reg <= (dec_cls == CLS_LW) ? ST_WB : ST_IDLE;
          else if (timeout_hit) state_reg <= ST_IDLE;
          else                  wait_reg  <= wait_reg + WAIT_W'(1);
        end
        ST_WB:   state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state_reg == ST_IDLE);
  assign bus.alu_op      = (state_reg == ST_EXEC || in_mem || state_reg == ST_WB) ? dec_alu : ALU_ADD;
  assign bus.reg_write   = (state_reg == ST_WB);
  assign bus.reg_dst     = (state_reg == ST_WB) && dec_rd;
  assign bus.mem_read    = in_mem && (dec_cls == CLS_LW);
  assign bus.mem_write   = in_mem && (dec_cls == CLS_SW);
  assign bus.done        = done_w;
  assign bus.illegal     = (state_reg == ST_DECODE) && (dec_cls == CLS_ILL);
  assign bus.mem_err     = timeout_hit;
  assign bus.retired     = retired_reg;

endmodule
